// File: rtl/spy_readout_sequencer.sv
// spy_readout_sequencer
//   Snapshot-and-drain controller for one spy buffer channel. A trigger
//   freezes the spy memory, waits FREEZE_SETTLE cycles for in-flight writes
//   to land, then latches the window (oldest word .. newest word). The
//   window is read out through the one-cycle-latency read port into a
//   2-entry fall-through FIFO and streamed downstream over valid/ready.
//   Freeze is released when the readout completes or is aborted.
//
// Optional feature macro: SPY_READOUT_HEADER_EN
//   When defined, a header word {1, 8'hF0, zeros, word_count} precedes
//   the data words of every readout.
//
// Ports
//   clock, reset       single clock, synchronous active-high reset
//   trigger, abort     start a readout (IDLE only) / cancel one (any state)
//   mem_wptr           spy memory next-write address
//   mem_looped         spy memory has wrapped at least once
//   freeze             freeze request to the spy buffer controller
//   read_addr          spy memory read address
//   read_enable        read strobe, read_data valid exactly one cycle later
//   read_data          spy memory read data
//   out_data           streamed word (MSB = metadata flag)
//   out_valid          out_data valid
//   out_ready          downstream accept
//   out_last           final word of the readout
//   word_count         words latched for the current readout
//   busy               high in any state except IDLE
//   done               one-cycle pulse on normal completion
module spy_readout_sequencer #(
   parameter int DATAWIDTH     = 64,
   parameter int MEMWIDTH      = 6,
   parameter int FREEZE_SETTLE = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  trigger,
   input  logic                  abort,
   input  logic [MEMWIDTH-1:0]   mem_wptr,
   input  logic                  mem_looped,
   output logic                  freeze,
   output logic [MEMWIDTH-1:0]   read_addr,
   output logic                  read_enable,
   input  logic [DATAWIDTH:0]    read_data,
   output logic [DATAWIDTH:0]    out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic [MEMWIDTH:0]     word_count,
   output logic                  busy,
   output logic                  done
);

   localparam int CW = MEMWIDTH + 1;
   localparam int SW = (FREEZE_SETTLE > 1) ? $clog2(FREEZE_SETTLE) : 1;
   localparam logic [CW-1:0] FULL_COUNT  = {1'b1, {MEMWIDTH{1'b0}}};
   localparam logic [CW-1:0] ONE_C       = {{MEMWIDTH{1'b0}}, 1'b1};
   localparam logic [SW-1:0] SETTLE_LAST = SW'(FREEZE_SETTLE - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETTLE = 3'd1,
      S_READ   = 3'd2,
      S_DRAIN  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [SW-1:0]         settle_cnt_q, settle_cnt_d;
   logic [MEMWIDTH-1:0]   start_q, start_d;
   logic [CW-1:0]         count_q, count_d;
   logic [CW-1:0]         issued_q, issued_d;
   logic [CW-1:0]         word_count_q, word_count_d;
   logic                  inflight_q, inflight_d;
   logic                  inflight_last_q, inflight_last_d;
   logic [DATAWIDTH:0]    fifo_data_q [2];
   logic [DATAWIDTH:0]    fifo_data_d [2];
   logic                  fifo_last_q [2];
   logic                  fifo_last_d [2];
   logic                  fifo_rd_q, fifo_rd_d;
   logic                  fifo_wr_q, fifo_wr_d;
   logic [1:0]            fifo_occ_q, fifo_occ_d;

   logic                  settle_exit_s;
   logic [MEMWIDTH-1:0]   lat_start_s;
   logic [CW-1:0]         lat_count_s;
   logic                  read_ok_s;
   logic                  last_read_s;
   logic                  fifo_empty_s;
   logic                  head_valid_s;
   logic [DATAWIDTH:0]    head_data_s;
   logic                  head_last_s;
   logic                  pop_s;
   logic                  data_push_s;
   logic                  hdr_push_s;
   logic                  push_s;
   logic [DATAWIDTH:0]    push_data_s;
   logic                  push_last_s;
   logic [DATAWIDTH:0]    hdr_word_s;

   // Window latch values, read-issue qualification and FIFO head selection.
   always_comb begin
      settle_exit_s = (state_q == S_SETTLE) && (settle_cnt_q == SETTLE_LAST);
      if (mem_looped) begin
         lat_start_s = mem_wptr;
         lat_count_s = FULL_COUNT;
      end else begin
         lat_start_s = {MEMWIDTH{1'b0}};
         lat_count_s = {1'b0, mem_wptr};
      end
      // At most two words may be stored or on their way back from memory.
      read_ok_s   = (state_q == S_READ) && !abort && (issued_q != count_q) &&
                    ((fifo_occ_q + {1'b0, inflight_q}) < 2'd2);
      last_read_s = read_ok_s && ((issued_q + ONE_C) == count_q);
      fifo_empty_s = (fifo_occ_q == 2'd0);
      // Fall-through: returning read data is presented the cycle it arrives.
      if (!fifo_empty_s) begin
         head_data_s = fifo_data_q[fifo_rd_q];
         head_last_s = fifo_last_q[fifo_rd_q];
      end else begin
         head_data_s = read_data;
         head_last_s = inflight_last_q;
      end
      head_valid_s = !fifo_empty_s || inflight_q;
      pop_s        = head_valid_s && out_ready && !fifo_empty_s;
      // Store returning data unless it leaves straight through the bypass.
      data_push_s  = inflight_q && !(fifo_empty_s && out_ready);
   end

`ifdef SPY_READOUT_HEADER_EN
   // Header word built from the count being latched this cycle.
   always_comb begin
      hdr_word_s                   = {(DATAWIDTH+1){1'b0}};
      hdr_word_s[DATAWIDTH]        = 1'b1;
      hdr_word_s[DATAWIDTH-1 -: 8] = 8'hF0;
      hdr_word_s[MEMWIDTH:0]       = lat_count_s;
      hdr_push_s                   = settle_exit_s;
   end
`else
   // No header in this build.
   always_comb begin
      hdr_word_s = {(DATAWIDTH+1){1'b0}};
      hdr_push_s = 1'b0;
   end
`endif

   // FIFO write port: header on window latch, otherwise returning read data.
   always_comb begin
      push_s = data_push_s || hdr_push_s;
      if (hdr_push_s) begin
         push_data_s = hdr_word_s;
         push_last_s = (lat_count_s == {CW{1'b0}});
      end else begin
         push_data_s = read_data;
         push_last_s = inflight_last_q;
      end
   end

   // Next-state logic of the readout FSM; abort overrides every transition.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (trigger) state_d = S_SETTLE;
            else         state_d = S_IDLE;
         end
         S_SETTLE: begin
            if (settle_exit_s) begin
               if (lat_count_s == {CW{1'b0}}) state_d = S_DONE;
               else                           state_d = S_READ;
            end else begin
               state_d = S_SETTLE;
            end
         end
         S_READ: begin
            if (last_read_s) state_d = S_DRAIN;
            else             state_d = S_READ;
         end
         S_DRAIN: begin
            if (fifo_empty_s && !inflight_q) state_d = S_DONE;
            else                             state_d = S_DRAIN;
         end
         S_DONE: begin
            // Waits only when a header-only readout is still queued.
            if (fifo_empty_s) state_d = S_IDLE;
            else              state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
      if (abort) state_d = S_IDLE;
      else       state_d = state_d;
   end

   // Settle timer, window registers, read counter and in-flight tracking.
   always_comb begin
      if (state_q == S_SETTLE) settle_cnt_d = settle_cnt_q + SW'(1);
      else                     settle_cnt_d = {SW{1'b0}};
      if (settle_exit_s) begin
         start_d      = lat_start_s;
         count_d      = lat_count_s;
         word_count_d = lat_count_s;
         issued_d     = {CW{1'b0}};
      end else begin
         start_d      = start_q;
         count_d      = count_q;
         word_count_d = word_count_q;
         if (read_ok_s) issued_d = issued_q + ONE_C;
         else           issued_d = issued_q;
      end
      // read_ok_s is already low on abort, so late data is never captured.
      inflight_d      = read_ok_s;
      inflight_last_d = last_read_s;
   end

   // FIFO pointers, occupancy and storage; abort flushes it.
   always_comb begin
      fifo_data_d = fifo_data_q;
      fifo_last_d = fifo_last_q;
      fifo_rd_d   = fifo_rd_q;
      fifo_wr_d   = fifo_wr_q;
      fifo_occ_d  = fifo_occ_q;
      if (abort) begin
         fifo_rd_d  = 1'b0;
         fifo_wr_d  = 1'b0;
         fifo_occ_d = 2'd0;
      end else begin
         if (push_s) begin
            fifo_data_d[fifo_wr_q] = push_data_s;
            fifo_last_d[fifo_wr_q] = push_last_s;
            fifo_wr_d              = ~fifo_wr_q;
         end else begin
            fifo_wr_d = fifo_wr_q;
         end
         if (pop_s) fifo_rd_d = ~fifo_rd_q;
         else       fifo_rd_d = fifo_rd_q;
         case ({push_s, pop_s})
            2'b10:   fifo_occ_d = fifo_occ_q + 2'd1;
            2'b01:   fifo_occ_d = fifo_occ_q - 2'd1;
            default: fifo_occ_d = fifo_occ_q;
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q         <= S_IDLE;
         settle_cnt_q    <= {SW{1'b0}};
         start_q         <= {MEMWIDTH{1'b0}};
         count_q         <= {CW{1'b0}};
         issued_q        <= {CW{1'b0}};
         word_count_q    <= {CW{1'b0}};
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         fifo_data_q[0]  <= {(DATAWIDTH+1){1'b0}};
         fifo_data_q[1]  <= {(DATAWIDTH+1){1'b0}};
         fifo_last_q[0]  <= 1'b0;
         fifo_last_q[1]  <= 1'b0;
         fifo_rd_q       <= 1'b0;
         fifo_wr_q       <= 1'b0;
         fifo_occ_q      <= 2'd0;
      end else begin
         state_q         <= state_d;
         settle_cnt_q    <= settle_cnt_d;
         start_q         <= start_d;
         count_q         <= count_d;
         issued_q        <= issued_d;
         word_count_q    <= word_count_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
         fifo_data_q     <= fifo_data_d;
         fifo_last_q     <= fifo_last_d;
         fifo_rd_q       <= fifo_rd_d;
         fifo_wr_q       <= fifo_wr_d;
         fifo_occ_q      <= fifo_occ_d;
      end
   end

   // Output decode from state and FIFO head.
   always_comb begin
      freeze      = (state_q == S_SETTLE) || (state_q == S_READ) || (state_q == S_DRAIN);
      busy        = (state_q != S_IDLE);
      done        = (state_q == S_DONE) && fifo_empty_s && !abort;
      read_enable = read_ok_s;
      if (state_q == S_READ) read_addr = start_q + issued_q[MEMWIDTH-1:0];
      else                   read_addr = {MEMWIDTH{1'b0}};
      out_valid   = head_valid_s;
      if (head_valid_s) begin
         out_data = head_data_s;
         out_last = head_last_s;
      end else begin
         out_data = {(DATAWIDTH+1){1'b0}};
         out_last = 1'b0;
      end
      word_count  = word_count_q;
   end

endmodule

// File: tb/tb_spy_readout_sequencer.sv
// Directed bench for spy_readout_sequencer: a table of readout scenarios
// plus hand-written abort / reset / trigger-collision sequences. A
// behavioural spy memory answers reads one cycle after read_enable; the
// expected word stream is built from the memory contents and the window
// rule (oldest to newest).
module tb_spy_readout_sequencer;

   localparam int DW = 64;
   localparam int MW = 6;
`ifdef SPY_READOUT_HEADER_EN
   localparam int HDR = 1;
`else
   localparam int HDR = 0;
`endif

   logic          clock;
   logic          reset;
   logic          trigger;
   logic          abort;
   logic [MW-1:0] mem_wptr;
   logic          mem_looped;
   logic          freeze;
   logic [MW-1:0] read_addr;
   logic          read_enable;
   logic [DW:0]   read_data;
   logic [DW:0]   out_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;
   logic [MW:0]   word_count;
   logic          busy;
   logic          done;

   spy_readout_sequencer #(.DATAWIDTH(DW), .MEMWIDTH(MW), .FREEZE_SETTLE(2)) dut (
      .clock(clock), .reset(reset), .trigger(trigger), .abort(abort),
      .mem_wptr(mem_wptr), .mem_looped(mem_looped), .freeze(freeze),
      .read_addr(read_addr), .read_enable(read_enable), .read_data(read_data),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .word_count(word_count), .busy(busy), .done(done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [DW:0] data;
      logic        last;
      logic        hdr;
   } exp_t;

   typedef struct {
      logic       looped;
      logic [5:0] wptr;
      int         ready_mode;   // 0: always ready, 1: 1,0,0,1 pattern
      int         extra_trig;   // loop cycle of a second trigger, -1 none
      int         exp_count;
      int         exp_words;    // data words expected (header added separately)
      int         exp_freeze;   // freeze-high cycles, -1 not checked
      int         chk_lat;      // check first out_valid 1 cycle after first read
   } vec_t;

   logic [DW:0] mem [64];
   exp_t        exp_q [$];
   exp_t        mon_e;
   vec_t        vecs [6];

   int total_cnt = 0;
   int bad_cnt   = 0;
   int cyc_n     = 0;
   int acc_cnt   = 0;
   int done_cnt  = 0;
   int freeze_cyc = 0;
   int first_re  = -1;
   int first_val = -1;
   int outstanding = 0;
   logic          stall_prev = 1'b0;
   logic [DW:0]   prev_data;
   logic          prev_last;

   task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
      total_cnt++;
      if (act !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Spy memory: registered read port, data valid one cycle after the strobe.
   always @(posedge clock) begin
      if (read_enable) read_data <= mem[read_addr];
   end

   // Output monitor: scoreboard, stall stability, read-issue limit, pulse counts.
   always @(negedge clock) begin
      cyc_n++;
      if (reset) begin
         outstanding = 0;
         stall_prev  = 1'b0;
      end else begin
         if (stall_prev)
            chk("stall_hold", {out_valid, out_last, out_data}, {1'b1, prev_last, prev_data});
         if (read_enable) begin
            if (first_re < 0) first_re = cyc_n;
            chk("read_limit", 72'(outstanding < 2), 72'd1);
         end
         if (out_valid && first_val < 0) first_val = cyc_n;
         if (freeze) freeze_cyc++;
         if (done) done_cnt++;
         if (out_valid && out_ready) begin
            acc_cnt++;
            if (exp_q.size() == 0) begin
               total_cnt++;
               bad_cnt++;
               $display("FAIL extra_word: got %h want none", out_data);
            end else begin
               mon_e = exp_q.pop_front();
               chk("word_data", 72'(out_data), 72'(mon_e.data));
               chk("word_last", 72'(out_last), 72'(mon_e.last));
               if (!mon_e.hdr && outstanding > 0) outstanding--;
            end
         end
         if (read_enable) outstanding++;
         if (abort) outstanding = 0;
         stall_prev = out_valid && !out_ready && !abort;
         prev_data  = out_data;
         prev_last  = out_last;
      end
   end

   task automatic build_expected(input logic lp, input logic [5:0] wp);
      int   cnt;
      int   st;
      exp_t e;
      exp_q.delete();
      cnt = lp ? 64 : int'(wp);
      st  = lp ? int'(wp) : 0;
`ifdef SPY_READOUT_HEADER_EN
      e.data = {1'b1, 8'hF0, 49'd0, 7'(cnt)};
      e.last = (cnt == 0);
      e.hdr  = 1'b1;
      exp_q.push_back(e);
`endif
      for (int k = 0; k < cnt; k++) begin
         e.data = mem[(st + k) % 64];
         e.last = (k == cnt - 1);
         e.hdr  = 1'b0;
         exp_q.push_back(e);
      end
   endtask

   task automatic clear_stats();
      acc_cnt    = 0;
      done_cnt   = 0;
      freeze_cyc = 0;
      first_re   = -1;
      first_val  = -1;
   endtask

   task automatic run_vec(input vec_t v);
      int fin;
      build_expected(v.looped, v.wptr);
      clear_stats();
      mem_looped = v.looped;
      mem_wptr   = v.wptr;
      out_ready  = 1'b1;
      trigger    = 1'b1;
      @(posedge clock); #1;
      fin = 0;
      for (int c = 0; c < 2000 && fin == 0; c++) begin
         if (v.ready_mode == 0) out_ready = 1'b1;
         else                   out_ready = ((c % 4) == 0) || ((c % 4) == 3);
         trigger = (c == v.extra_trig);
         @(posedge clock); #1;
         if (done_cnt != 0) fin = 1;
      end
      trigger   = 1'b0;
      out_ready = 1'b1;
      repeat (4) begin @(posedge clock); #1; end
      chk("done_pulses", 72'(done_cnt), 72'd1);
      chk("word_count", 72'(word_count), 72'(v.exp_count));
      chk("words_out", 72'(acc_cnt), 72'(v.exp_words + HDR));
      chk("words_left", 72'(exp_q.size()), 72'd0);
      chk("idle_after", {70'd0, freeze, busy}, 72'd0);
      if (v.exp_freeze >= 0) chk("freeze_cycles", 72'(freeze_cyc), 72'(v.exp_freeze));
      if (v.chk_lat != 0 && HDR == 0) chk("first_latency", 72'(first_val - first_re), 72'd1);
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_freeze"}, 72'(freeze), 72'd0);
      chk({nm, "_rden"}, 72'(read_enable), 72'd0);
      chk({nm, "_raddr"}, 72'(read_addr), 72'd0);
      chk({nm, "_valid"}, 72'(out_valid), 72'd0);
      chk({nm, "_data"}, 72'(out_data), 72'd0);
      chk({nm, "_last"}, 72'(out_last), 72'd0);
      chk({nm, "_wcount"}, 72'(word_count), 72'd0);
      chk({nm, "_busy"}, 72'(busy), 72'd0);
      chk({nm, "_done"}, 72'(done), 72'd0);
   endtask

   initial begin
      vec_t rv;
      int   snap;
      reset      = 1'b1;
      trigger    = 1'b0;
      abort      = 1'b0;
      mem_wptr   = 6'd0;
      mem_looped = 1'b0;
      out_ready  = 1'b0;
      read_data  = '0;
      for (int i = 0; i < 64; i++)
         mem[i] = {1'(i % 2), 16'hBEEF, 16'(i), 32'(i * 32'h01010101) ^ 32'h5A5A5A5A};

      //            looped wptr  mode extra cnt words freeze lat
      vecs[0] = '{1'b0, 6'd5,  0, -1,  5,  5, -1, 1};
      vecs[1] = '{1'b1, 6'd10, 0, -1, 64, 64, -1, 1};
      vecs[2] = '{1'b0, 6'd20, 1, -1, 20, 20, -1, 0};
      vecs[3] = '{1'b0, 6'd0,  0, -1,  0,  0,  2, 0};
      vecs[4] = '{1'b0, 6'd8,  0,  6,  8,  8, -1, 0};
      vecs[5] = '{1'b1, 6'd0,  1, -1, 64, 64, -1, 0};

      repeat (2) begin @(posedge clock); #1; end
      chk_all_zero("reset");
      reset = 1'b0;
      @(posedge clock); #1;

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Abort after three accepted words, then replay the whole window.
      build_expected(1'b0, 6'd20);
      clear_stats();
      mem_looped = 1'b0;
      mem_wptr   = 6'd20;
      out_ready  = 1'b1;
      trigger    = 1'b1;
      @(posedge clock); #1;
      trigger = 1'b0;
      for (int c = 0; c < 100 && acc_cnt < 3; c++) begin @(posedge clock); #1; end
      chk("abort_reached", 72'(acc_cnt >= 3), 72'd1);
      abort = 1'b1;
      @(posedge clock); #1;
      abort = 1'b0;
      chk("abort_state", {69'd0, busy, freeze, out_valid}, 72'd0);
      snap = acc_cnt;
      repeat (4) begin @(posedge clock); #1; end
      chk("abort_quiet", {70'd0, out_valid, busy}, 72'd0);
      chk("abort_no_more", 72'(acc_cnt), 72'(snap));
      chk("abort_no_done", 72'(done_cnt), 72'd0);
      rv = '{1'b0, 6'd20, 0, -1, 20, 20, -1, 0};
      run_vec(rv);

      // Reset while stalled with data queued at the end of the readout.
      exp_q.delete();
      clear_stats();
      out_ready  = 1'b0;
      mem_looped = 1'b0;
      mem_wptr   = 6'd2;
      trigger    = 1'b1;
      @(posedge clock); #1;
      trigger = 1'b0;
      repeat (7) begin @(posedge clock); #1; end
      chk("drain_busy", {70'd0, busy, out_valid}, 72'd3);
      chk("drain_wcount", 72'(word_count), 72'd2);
      reset = 1'b1;
      @(posedge clock); #1;
      chk_all_zero("midreset");
      reset = 1'b0;
      out_ready = 1'b1;
      @(posedge clock); #1;

      // Abort and trigger together in IDLE: abort wins.
      clear_stats();
      exp_q.delete();
      mem_wptr = 6'd4;
      trigger  = 1'b1;
      abort    = 1'b1;
      @(posedge clock); #1;
      trigger = 1'b0;
      abort   = 1'b0;
      chk("collide_idle", {70'd0, busy, freeze}, 72'd0);
      repeat (3) begin @(posedge clock); #1; end
      chk("collide_stay", {69'd0, busy, out_valid, read_enable}, 72'd0);
      chk("collide_words", 72'(acc_cnt), 72'd0);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
